// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: arbiter-PUF challenge/response sequencer with majority voting and LFSR challenge walk
// Ports: wb_clk_i clock, wb_rst_ni async active-low reset; req_valid/req_ready/req_challenge seed request;
//        puf_challenge/puf_pulse drive the PUF, puf_response is its asynchronous output;
//        resp_valid/resp_ready/resp_data/resp_unstable carry the voted bits and per-bit instability mask.
module puf_eval_ctrl #(
  parameter int SETTLE_CYC  = 4,
  parameter int PULSE_CYC   = 2,
  parameter int CAPTURE_CYC = 4,
  parameter int VOTES       = 5,
  parameter int RESP_W      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_challenge,
  output logic [15:0]       puf_challenge,
  output logic              puf_pulse,
  input  logic              puf_response,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [RESP_W-1:0] resp_unstable
);
  localparam int BW = RESP_W > 1 ? $clog2(RESP_W) : 1;
  localparam logic [15:0]   L_SET   = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]   L_PUL   = 16'(PULSE_CYC - 1);
  localparam logic [15:0]   L_CAP   = 16'(CAPTURE_CYC - 1);
  localparam logic [3:0]    L_VOTES = 4'(VOTES);
  localparam logic [3:0]    L_HALF  = 4'(VOTES / 2);
  localparam logic [BW-1:0] L_LAST  = BW'(RESP_W - 1);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_PULSE, S_WAIT, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [15:0]       r_cnt, r_chal, w_lfsr;
  logic [3:0]        r_votes, r_ones, w_ones;
  logic [BW-1:0]     r_bit;
  logic [1:0]        r_sync;
  logic              r_valid, w_last, w_accept, w_sample, w_vote_done, w_bit_done;
  logic [RESP_W-1:0] r_data, r_unst;
  assign w_accept    = req_valid && r_state == S_IDLE;
  assign w_sample    = r_state == S_WAIT && w_last;
  // the vote currently being sampled is included in w_ones
  assign w_ones      = r_ones + {3'b0, r_sync[1]};
  assign w_vote_done = r_votes + 4'd1 == L_VOTES;
  assign w_bit_done  = r_bit == L_LAST;
  assign w_lfsr      = {r_chal[14:0], r_chal[15] ^ r_chal[13] ^ r_chal[12] ^ r_chal[10]};
  assign req_ready     = r_state == S_IDLE;
  assign puf_pulse     = r_state == S_PULSE;
  assign puf_challenge = r_chal;
  assign resp_valid    = r_valid;
  assign resp_data     = r_data;
  assign resp_unstable = r_unst;
  always_comb w_last = r_state == S_SETTLE ? r_cnt == L_SET : r_state == S_PULSE ? r_cnt == L_PUL : r_cnt == L_CAP;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_SETTLE;
      S_SETTLE: if (w_last) w_next = S_PULSE;
      S_PULSE:  if (w_last) w_next = S_WAIT;
      S_WAIT:   if (w_last) w_next = w_vote_done && w_bit_done ? S_DONE : S_SETTLE;
      S_DONE:   if (r_valid && resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) r_state <= S_IDLE;
    else r_state <= w_next;
  // resp_valid is registered off DONE, so it rises one cycle after the last sample
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_chal  <= '0;
      r_votes <= '0;
      r_ones  <= '0;
      r_bit   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_unst  <= '0;
    end else begin
      r_sync  <= {r_sync[0], puf_response};
      r_cnt   <= w_next != r_state ? 16'd0 : r_cnt + 16'd1;
      r_valid <= r_state == S_DONE && !(r_valid && resp_ready);
      if (w_accept) begin
        r_chal  <= req_challenge;
        r_bit   <= '0;
        r_votes <= '0;
        r_ones  <= '0;
        r_data  <= '0;
        r_unst  <= '0;
      end else if (w_sample) begin
        if (!w_vote_done) begin
          r_votes <= r_votes + 4'd1;
          r_ones  <= w_ones;
        end else begin
          r_data[r_bit] <= w_ones > L_HALF;
          r_unst[r_bit] <= w_ones != 4'd0 && w_ones != L_VOTES;
          r_votes       <= '0;
          r_ones        <= '0;
          if (!w_bit_done) begin
            r_chal <= w_lfsr;
            r_bit  <= r_bit + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: randomized self-checking bench for puf_eval_ctrl against a behavioural PUF and vote model
module tb_puf_eval_ctrl;
  localparam int VOTES = 5;
  localparam int RESP_W = 8;
  logic wb_clk_i = 0, wb_rst_ni = 0, req_valid = 0, resp_ready = 0, puf_response = 0;
  logic [15:0] req_challenge = '0;
  logic req_ready, puf_pulse, resp_valid;
  logic [15:0] puf_challenge;
  logic [RESP_W-1:0] resp_data, resp_unstable;
  int n_checks = 0, n_fail = 0, cyc = 0, acc = 0, mode = 0, p_idx;
  logic [4:0] noisy_pat = '0;
  logic gen;
  time rise_t[$], fall_t[$];
  logic [15:0] rise_c[$], fall_c[$];
  logic gen_q[$];

  puf_eval_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .req_valid(req_valid), .req_ready(req_ready),
    .req_challenge(req_challenge), .puf_challenge(puf_challenge), .puf_pulse(puf_pulse),
    .puf_response(puf_response), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_unstable(resp_unstable)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // PUF model: a new response is produced on each pulse and held until the next one
  always @(posedge puf_pulse) begin
    p_idx = rise_t.size();
    rise_t.push_back($time);
    rise_c.push_back(puf_challenge);
    gen = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? puf_challenge[0] :
          mode == 3 ? (p_idx / VOTES == 3 ? noisy_pat[p_idx % VOTES] : 1'b1) : 1'($urandom_range(0, 1));
    puf_response = gen;
    gen_q.push_back(gen);
  end
  always @(negedge puf_pulse) begin
    fall_t.push_back($time);
    fall_c.push_back(puf_challenge);
  end

  function automatic logic [15:0] lfsr_n(input logic [15:0] s, input int n);
    logic [15:0] c = s;
    for (int i = 0; i < n; i++) c = {c[14:0], c[15] ^ c[13] ^ c[12] ^ c[10]};
    return c;
  endfunction

  // expected {unstable, data} from the recorded per-pulse PUF outputs
  function automatic logic [15:0] model_res();
    logic [7:0] d = '0, u = '0;
    for (int k = 0; k < RESP_W; k++) begin
      int ones = 0;
      for (int v = 0; v < VOTES; v++)
        if (k * VOTES + v < gen_q.size()) ones += int'(gen_q[k * VOTES + v]);
      d[k] = ones > VOTES / 2;
      u[k] = ones != 0 && ones != VOTES;
    end
    return {u, d};
  endfunction

  function automatic int timing_errs();
    int e = 0;
    for (int i = 0; i < rise_t.size(); i++) begin
      if (i >= fall_t.size() || fall_t[i] - rise_t[i] != 20) e++;
      if (i > 0 && rise_t[i] - rise_t[i-1] != 100) e++;
    end
    return e;
  endfunction

  function automatic int chal_errs(input logic [15:0] seed);
    int e = 0;
    for (int i = 0; i < rise_c.size(); i++) begin
      if (rise_c[i] !== lfsr_n(seed, i / VOTES)) e++;
      if (i >= fall_c.size() || fall_c[i] !== lfsr_n(seed, i / VOTES)) e++;
    end
    return e;
  endfunction

  task automatic clr();
    rise_t.delete(); fall_t.delete(); rise_c.delete(); fall_c.delete(); gen_q.delete();
  endtask

  task automatic start_req(input logic [15:0] seed);
    @(negedge wb_clk_i);
    req_valid = 1;
    req_challenge = seed;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    acc = cyc;
    req_valid = 0;
  endtask

  task automatic wait_resp(output int l);
    int n = 0;
    while (!resp_valid && n < 3000) begin
      @(negedge wb_clk_i);
      n++;
    end
    l = resp_valid ? cyc - acc : -1;
  endtask

  task automatic ack();
    resp_ready = 1;
    @(negedge wb_clk_i);
    resp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge wb_clk_i);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (puf_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", puf_pulse); end
    n_checks++; if (puf_challenge !== 16'h0) begin n_fail++; $display("FAIL reset_challenge got %h want 0000", puf_challenge); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_checks++; if (resp_data !== 8'h0) begin n_fail++; $display("FAIL reset_resp_data got %h want 00", resp_data); end
    n_checks++; if (resp_unstable !== 8'h0) begin n_fail++; $display("FAIL reset_unstable got %h want 00", resp_unstable); end
    wb_rst_ni = 1;
    @(negedge wb_clk_i);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_const_one();
    int l;
    logic [15:0] m;
    mode = 1; clr(); start_req(16'hACE1); wait_resp(l);
    m = model_res();
    n_checks++; if (l != 401) begin n_fail++; $display("FAIL const1_latency got %0d want 401", l); end
    n_checks++; if (resp_data !== 8'hFF) begin n_fail++; $display("FAIL const1_data got %h want FF", resp_data); end
    n_checks++; if (resp_unstable !== 8'h00) begin n_fail++; $display("FAIL const1_unstable got %h want 00", resp_unstable); end
    n_checks++; if ({resp_unstable, resp_data} !== m) begin n_fail++; $display("FAIL const1_model got %h want %h", {resp_unstable, resp_data}, m); end
    n_checks++; if (rise_t.size() != RESP_W * VOTES) begin n_fail++; $display("FAIL const1_pulse_count got %0d want %0d", rise_t.size(), RESP_W * VOTES); end
    n_checks++; if (chal_errs(16'hACE1) != 0) begin n_fail++; $display("FAIL const1_challenges got %0d bad want 0", chal_errs(16'hACE1)); end
    ack();
  endtask

  task automatic test_chal_bit0();
    int l;
    logic [15:0] c;
    logic [7:0] e = '0;
    for (int k = 0; k < RESP_W; k++) begin
      c = lfsr_n(16'h0001, k);
      e[k] = c[0];
    end
    mode = 2; clr(); start_req(16'h0001); wait_resp(l);
    n_checks++; if (l != 401) begin n_fail++; $display("FAIL bit0_latency got %0d want 401", l); end
    n_checks++; if (resp_data !== e) begin n_fail++; $display("FAIL bit0_data got %h want %h", resp_data, e); end
    n_checks++; if (resp_unstable !== 8'h00) begin n_fail++; $display("FAIL bit0_unstable got %h want 00", resp_unstable); end
    n_checks++; if (timing_errs() != 0) begin n_fail++; $display("FAIL bit0_pulse_timing got %0d bad want 0", timing_errs()); end
    n_checks++; if (chal_errs(16'h0001) != 0) begin n_fail++; $display("FAIL bit0_challenges got %0d bad want 0", chal_errs(16'h0001)); end
    ack();
  endtask

  task automatic test_noisy();
    int l;
    logic [15:0] m;
    mode = 3; noisy_pat = 5'b01011; clr(); start_req(16'h3C5A); wait_resp(l);
    m = model_res();
    n_checks++; if (resp_data !== 8'hFF) begin n_fail++; $display("FAIL noisy1_data got %h want FF", resp_data); end
    n_checks++; if (resp_unstable !== 8'h08) begin n_fail++; $display("FAIL noisy1_unstable got %h want 08", resp_unstable); end
    n_checks++; if ({resp_unstable, resp_data} !== m) begin n_fail++; $display("FAIL noisy1_model got %h want %h", {resp_unstable, resp_data}, m); end
    ack();
    noisy_pat = 5'b10100; clr(); start_req(16'h3C5A); wait_resp(l);
    m = model_res();
    n_checks++; if (resp_data !== 8'hF7) begin n_fail++; $display("FAIL noisy2_data got %h want F7", resp_data); end
    n_checks++; if (resp_unstable !== 8'h08) begin n_fail++; $display("FAIL noisy2_unstable got %h want 08", resp_unstable); end
    n_checks++; if ({resp_unstable, resp_data} !== m) begin n_fail++; $display("FAIL noisy2_model got %h want %h", {resp_unstable, resp_data}, m); end
    ack();
  endtask

  task automatic test_backpressure();
    int l, bad = 0, nr;
    logic [7:0] d, u;
    mode = 4; clr(); start_req(16'h7E11);
    repeat (100) @(negedge wb_clk_i);
    req_valid = 1; req_challenge = 16'h1234;
    repeat (3) @(negedge wb_clk_i);
    req_valid = 0;
    wait_resp(l);
    n_checks++; if (l != 401) begin n_fail++; $display("FAIL bp_latency got %0d want 401", l); end
    n_checks++; if (chal_errs(16'h7E11) != 0) begin n_fail++; $display("FAIL bp_busy_req_ignored got %0d bad want 0", chal_errs(16'h7E11)); end
    n_checks++; if ({resp_unstable, resp_data} !== model_res()) begin n_fail++; $display("FAIL bp_model got %h want %h", {resp_unstable, resp_data}, model_res()); end
    d = resp_data; u = resp_unstable; nr = rise_t.size();
    for (int i = 0; i < 50; i++) begin
      @(negedge wb_clk_i);
      req_valid = i >= 20 && i < 23;
      if (resp_valid !== 1'b1 || resp_data !== d || resp_unstable !== u || req_ready !== 1'b0 || puf_pulse !== 1'b0) bad++;
    end
    req_valid = 0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    n_checks++; if (rise_t.size() != nr) begin n_fail++; $display("FAIL bp_no_pulses got %0d want %0d", rise_t.size(), nr); end
    ack();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req_ready got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got %b want 0", resp_valid); end
    n_checks++; if (resp_data !== d || resp_unstable !== u) begin n_fail++; $display("FAIL bp_persist got %h/%h want %h/%h", resp_data, resp_unstable, d, u); end
    mode = 1; clr(); start_req(16'hBEEF); wait_resp(l);
    n_checks++; if (l != 401 || resp_data !== 8'hFF) begin n_fail++; $display("FAIL bp_new_accept got lat %0d data %h want 401 FF", l, resp_data); end
    ack();
  endtask

  task automatic test_async_reset();
    int l, n = 0;
    mode = 1; clr(); start_req(16'h5A5A);
    while (!puf_pulse && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    n_checks++; if (puf_pulse !== 1'b1) begin n_fail++; $display("FAIL arst_pulse_seen got %b want 1", puf_pulse); end
    #2 wb_rst_ni = 0;
    #1;
    n_checks++; if (puf_pulse !== 1'b0) begin n_fail++; $display("FAIL arst_pulse got %b want 0", puf_pulse); end
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_hs got ready %b valid %b want 1 0", req_ready, resp_valid); end
    n_checks++; if (puf_challenge !== 16'h0 || resp_data !== 8'h0 || resp_unstable !== 8'h0) begin n_fail++; $display("FAIL arst_outputs got %h %h %h want 0", puf_challenge, resp_data, resp_unstable); end
    @(negedge wb_clk_i);
    wb_rst_ni = 1;
    @(negedge wb_clk_i);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release_ready got %b want 1", req_ready); end
    clr(); start_req(16'hACE1); wait_resp(l);
    n_checks++; if (l != 401 || resp_data !== 8'hFF || resp_unstable !== 8'h00) begin n_fail++; $display("FAIL arst_fresh got lat %0d data %h unst %h want 401 FF 00", l, resp_data, resp_unstable); end
    ack();
  endtask

  task automatic test_zero_seed();
    int l, bad = 0;
    mode = 0; clr(); start_req(16'h0000); wait_resp(l);
    foreach (rise_c[i]) if (rise_c[i] !== 16'h0) bad++;
    foreach (fall_c[i]) if (fall_c[i] !== 16'h0) bad++;
    n_checks++; if (l != 401) begin n_fail++; $display("FAIL zero_latency got %0d want 401", l); end
    n_checks++; if (bad != 0 || rise_c.size() != RESP_W * VOTES || puf_challenge !== 16'h0) begin n_fail++; $display("FAIL zero_challenge got %0d nonzero of %0d want 0 of 40", bad, rise_c.size()); end
    n_checks++; if (resp_data !== 8'h00 || resp_unstable !== 8'h00) begin n_fail++; $display("FAIL zero_result got %h/%h want 00/00", resp_data, resp_unstable); end
    ack();
  endtask

  task automatic test_random();
    int l;
    logic [15:0] s;
    for (int r = 0; r < 4; r++) begin
      s = 16'($urandom);
      mode = 4; clr(); start_req(s); wait_resp(l);
      n_checks++; if (l != 401) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 401", r, l); end
      n_checks++; if ({resp_unstable, resp_data} !== model_res()) begin n_fail++; $display("FAIL rand%0d_result got %h want %h", r, {resp_unstable, resp_data}, model_res()); end
      n_checks++; if (chal_errs(s) != 0) begin n_fail++; $display("FAIL rand%0d_challenges got %0d bad want 0", r, chal_errs(s)); end
      ack();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_const_one();
    test_chal_bit0();
    test_noisy();
    test_backpressure();
    test_async_reset();
    test_zero_seed();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
Challenge/response sequencer that drives the arbiter PUF's ipulse/ichallenge inputs and reads back its oresponse.
- Accepts a 16-bit seed challenge over a valid/ready request.
- Per response bit, applies a challenge, fires the race pulse, samples the synchronized response and majority-votes over repeated evaluations.
- Walks a 16-bit LFSR to derive the next challenge.
- Returns an RESP_W-bit response plus a per-bit instability mask.
- Sits in the user project area between host-side control logic and the PUF instance.

Parameters:
SETTLE_CYC, 4, cycles challenge held stable with pulse low before each pulse (>=1)
PULSE_CYC, 2, cycles puf_pulse held high (>=1)
CAPTURE_CYC, 4, cycles after pulse falls before sampling (>=3, covers 2-flop sync)
VOTES, 5, evaluations per response bit (odd, 1..15)
RESP_W, 8, response bits per request (1..32)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  controller idle, request accepted when req_valid&req_ready
req_challenge  in  16  seed challenge
puf_challenge  out  16  to PUF ichallenge
puf_pulse  out  1  to PUF ipulse
puf_response  in  1  from PUF oresponse, asynchronous
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  RESP_W  voted response, bit k from k-th challenge
resp_unstable  out  RESP_W  bit k set if votes for bit k not unanimous

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset is asynchronous, active-low (wb_rst_ni), and fixed as such.
- Reset values: req_ready=1, puf_challenge=0, puf_pulse=0, resp_valid=0, resp_data=0, resp_unstable=0. Sync flops, counters, vote tallies and bit index all clear to 0.
- puf_response passes through a 2-flop synchronizer; all decisions use the synchronized value.
- States: IDLE, SETTLE, PULSE, WAIT, DONE. req_ready=1 only in IDLE. puf_pulse=1 only in PULSE.
- IDLE, on req_valid&req_ready edge:
  - chal_reg<=req_challenge; puf_challenge follows chal_reg (registered).
  - bit_idx<=0, vote_cnt<=0, ones_cnt<=0; resp_data and resp_unstable cleared.
  - Go to SETTLE.
- SETTLE: hold SETTLE_CYC cycles, then PULSE.
- PULSE: hold PULSE_CYC cycles, then WAIT.
- WAIT, CAPTURE_CYC cycles. On the last cycle, sample the synced response: ones_cnt+=sync, vote_cnt+=1.
  - If vote_cnt+1<VOTES: go to SETTLE.
  - Else resolve bit_idx:
    - resp_data[bit_idx] = (ones_cnt_final > VOTES/2).
    - resp_unstable[bit_idx] = (ones_cnt_final != 0 && ones_cnt_final != VOTES).
    - If bit_idx==RESP_W-1: go to DONE.
    - Else: chal_reg <= lfsr(chal_reg), bit_idx+=1, tallies cleared, go to SETTLE.
- LFSR: next = {c[14:0], c[15]^c[13]^c[12]^c[10]}. A zero seed stays zero; this is legal and produces RESP_W evaluations of challenge 0.
- Challenge stability: puf_challenge changes only on the SETTLE entry edge, never while PULSE or WAIT is active.
- Latency: per-vote time T = SETTLE_CYC+PULSE_CYC+CAPTURE_CYC. resp_valid rises exactly 1+RESP_W*VOTES*T cycles after the accept edge (defaults: 401).
- DONE: resp_valid=1; resp_data and resp_unstable are stable. On resp_valid&resp_ready: resp_valid<=0, go to IDLE. req_ready rises the cycle after, with no back-to-back accept in the same cycle.
- Outputs persist: resp_data and resp_unstable hold their values after handshake until the next accept.
- Back-pressure: DONE holds indefinitely while resp_ready=0.
- req_valid outside IDLE is ignored; it is not queued.
- Reset mid-operation: all state and outputs return immediately to reset values; any partial result is discarded; puf_pulse drops asynchronously.

Test Plan:
- Constant-1 PUF model, seed 16'hACE1, defaults -> resp_valid at accept+401 cycles, resp_data=8'hFF, resp_unstable=8'h00; puf_challenge sequence ACE1, lfsr(ACE1), ... checked against reference LFSR.
- PUF model response = challenge[0] (deterministic), seed 16'h0001 -> resp_data bits equal bit 0 of each LFSR successor; resp_unstable=0; pulse width 2 cycles, 4-cycle settle, per-vote spacing 10 cycles.
- Noisy model for bit 3: returns 1,1,0,1,0 across its five votes -> resp_data[3]=1, resp_unstable=8'h08. Second run with 0,0,1,0,1 -> resp_data[3]=0, resp_unstable[3]=1.
- Hold resp_ready=0 for 50 cycles after DONE; pulse req_valid during busy and DONE -> outputs stable, no puf_pulse activity, request ignored. Raise resp_ready -> IDLE, req_ready=1 next cycle, new accept works.
- Assert wb_rst_ni=0 asynchronously mid-PULSE -> puf_pulse=0 and outputs at reset values without waiting for a clock edge. After release, req_ready=1 and a fresh request completes in 401 cycles.
- Seed 16'h0000 with constant-0 model -> puf_challenge stays 0 throughout, resp_data=0, resp_unstable=0.
